gpio_mulcnt: RTL and testbench
==============================

# gpio_mulcnt

Bus-mapped arithmetic peripheral in the GPIO emulator: the next generation of the multiply/count engine. A host writes two operands over the `saddress`/`swr`/`srd` strobe bus, then triggers a start. An iterative shift-add multiplier produces the product, a popcount stage counts its ones, and status, result and ones-count are exposed as readable registers. Operand width, result width and operation-counter width are parameters; all bus strobes are sampled synchronously to `clk`.

## Interface
- `DATA_W`, default 24: operand width (A1, A2).
- `RES_W`, default 32: result register width. Elaboration error unless `RES_W <= 2*DATA_W` and `RES_W <= 32`.
- `CNT_W`, default 16: operation-counter width. Must satisfy `CNT_W <= 32`.
- `clk`, in, 1: single clock; everything is rising-edge.
- `n_reset`, in, 1: reset, asynchronous and active-low.
- `saddress`, in, 16: register address.
- `swr`, in, 1: write strobe (level); an action fires on its sampled rising edge.
- `srd`, in, 1: read strobe (level); an action fires on its sampled rising edge.
- `sdata_in`, in, 32: write data.
- `sdata_out`, out, 32: registered read data.
- `gpio_in`, in, 32: GPIO input bus.
- `gpio_latch`, in, 1: capture strobe for `gpio_in`.
- `gpio_out`, out, 32: zero-extended operation counter.
- `gpio_in_s_insp`, out, 32: captured GPIO input, for inspection.

## Operation
- **Address map:**
  - 0x037F, W: A1 (`sdata_in[DATA_W-1:0]`).
  - 0x0388, W: A2.
  - 0x0390, R: W result, zero-extended.
  - 0x0398, R: ones count, zero-extended.
  - 0x03A0, W: start (data ignored). 0x03A0, R: status `{29'b0, busy, valid, done}`.
- **Edge detection:** `swr_q` and `srd_q` register the previous strobe level. An event occurs when the strobe is 1 and its `_q` copy is 0. A held strobe gives exactly one event.
- **FSM states:** IDLE, MULT, COUNT, DONE.
  - IDLE: on a start event, latch A1/A2 into working registers, clear the accumulator, set busy=1, done=0, go to MULT.
  - MULT: exactly `DATA_W` cycles. Each cycle, if the multiplier LSB is 1, add the shifted multiplicand into a `2*DATA_W`-bit accumulator. Then shift the multiplicand left and the multiplier right.
  - COUNT: 1 cycle. Popcount of `acc[RES_W-1:0]`.
  - DONE: 1 cycle. Perform the result updates below, then return to IDLE.
- **DONE updates:**
  - W ← `acc[RES_W-1:0]`.
  - valid ← 1 iff `acc[2*DATA_W-1:RES_W]` is all zero (always 1 when `RES_W == 2*DATA_W`).
  - ones ← popcount result; done ← 1; busy ← 0.
  - Operation counter increments and wraps modulo `2^CNT_W`.
- **Writes while busy:** A1/A2 writes and start events are ignored. Operands are taken only at start.
- **Reads:** W and ones always return the last completed values (0 before the first completion).
- **Unmapped addresses:** reads return 0; writes have no effect.
- **Simultaneous events:** `srd` and `swr` events in the same cycle are both processed. A status read in the cycle DONE executes returns pre-DONE values.
- **GPIO capture:** on a `gpio_latch` rising edge (sampled), `gpio_in_s` ← `gpio_in`.
- **Output assignments:** `gpio_in_s_insp = gpio_in_s`; `gpio_out = {zeros, op_cnt}`.
- **Reset values:** all registers 0 except valid=1. Status reads 0x2; `sdata_out`, `gpio_out` and `gpio_in_s_insp` are 0; state is IDLE.
- **Reset mid-operation:** aborts the operation, all registers take reset values, and no count increment occurs.

## Timing
- Cycle 0 is the edge where a start event is sampled. Busy reads 1 from cycle 1.
- MULT spans cycles 1..`DATA_W`; COUNT is cycle `DATA_W+1`; DONE is cycle `DATA_W+2`.
- done=1, the new W/ones values and the incremented `gpio_out` are visible from cycle `DATA_W+3`.
- The next start is accepted from cycle `DATA_W+3`.
- `sdata_out` updates one cycle after a read event and holds until the next read event.
- Write side effects are visible one cycle after the write event.

## Configuration
- `GPIO_MULCNT_POPCNT_EN` defined: COUNT state and the popcount logic are present, and 0x0398 returns the ones count.
- Undefined: the FSM goes MULT → DONE directly, so latency drops by one cycle and done is visible from `DATA_W+2`. 0x0398 reads 0 and the popcount logic is absent.

## Structure
- Shared package `gpio_mulcnt_pkg`:
  - address localparams `ADDR_A1`, `ADDR_A2`, `ADDR_W`, `ADDR_ONES`, `ADDR_CTRL`;
  - FSM state enum `mulcnt_state_t`;
  - status bit indices.
- One sub-module `popcount #(W)`: combinational ones count of a W-bit vector, output width `$clog2(W+1)`.

## Test plan
Default parameters unless stated.
- Reset: status reads 0x2; W, ones and `gpio_out` are 0.
- A1=3, A2=5, start → after 26 cycles (done visible from cycle 27): W=15, ones=4, status=0x3, `gpio_out`=1.
- A1=A2=0xFFFFFF (product 0xFFFFFE000001): W=0xFE000001, valid=0, ones=8, status=0x1.
- Start, then at cycle 5 write A1=7 and issue a second start; result uses the original operands and `gpio_out` increments by 1 only.
- Assert `n_reset` low at cycle 10 of an operation: all registers back to reset values, `gpio_out`=0; a fresh operation then completes normally.
- `CNT_W`=4: 16 operations → `gpio_out`=0 (wrap). Hold `swr` high for 5 cycles on 0x03A0 → exactly one operation.

Source files
------------

// File: rtl/gpio_mulcnt_pkg.sv
// gpio_mulcnt_pkg: register map, FSM states and status bit positions shared by the multiply/count peripheral.
package gpio_mulcnt_pkg;

    localparam logic [15:0] ADDR_A1   = 16'h037F;
    localparam logic [15:0] ADDR_A2   = 16'h0388;
    localparam logic [15:0] ADDR_W    = 16'h0390;
    localparam logic [15:0] ADDR_ONES = 16'h0398;
    localparam logic [15:0] ADDR_CTRL = 16'h03A0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MULT,
        S_COUNT,
        S_DONE
    } mulcnt_state_t;

    localparam int STAT_DONE  = 0;
    localparam int STAT_VALID = 1;
    localparam int STAT_BUSY  = 2;

endpackage

// File: rtl/gpio_mulcnt_popcount.sv
// popcount: combinational count of the set bits in a W-bit vector.
module popcount #(
    parameter int W = 32
) (
    input  logic [W-1:0]             vec,
    output logic [$clog2(W+1)-1:0]   cnt
);

    localparam int CW = $clog2(W + 1);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < W; i++) cnt = cnt + CW'(vec[i]);
    end

endmodule

// File: rtl/gpio_mulcnt.sv
// gpio_mulcnt: bus-mapped shift-add multiplier with result/status registers and an operation counter.
// Define GPIO_MULCNT_POPCNT_EN to add the COUNT state and the ones-count register at 0x0398.
module gpio_mulcnt #(
    parameter int DATA_W = 24,
    parameter int RES_W  = 32,
    parameter int CNT_W  = 16
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [15:0] saddress,
    input  logic        swr,
    input  logic        srd,
    input  logic [31:0] sdata_in,
    output logic [31:0] sdata_out,
    input  logic [31:0] gpio_in,
    input  logic        gpio_latch,
    output logic [31:0] gpio_out,
    output logic [31:0] gpio_in_s_insp
);

    import gpio_mulcnt_pkg::*;

    localparam int SW = $clog2(DATA_W + 1);
    localparam int AW = 2 * DATA_W;

    if (RES_W > AW || RES_W > 32 || CNT_W > 32) begin : g_bad_params
        $error("gpio_mulcnt: RES_W must be <= 2*DATA_W and <= 32, CNT_W must be <= 32");
    end

    mulcnt_state_t      state, state_nxt;
    logic               swr_q, srd_q, latch_q;
    logic               wr_ev, rd_ev, latch_ev;
    logic [DATA_W-1:0]  a1_q, a2_q, mplier;
    logic [AW-1:0]      mcand, acc;
    logic [SW-1:0]      step;
    logic [RES_W-1:0]   w_q;
    logic               valid_q, done_q;
    logic [CNT_W-1:0]   op_cnt;
    logic [31:0]        gpio_in_s, rd_data, status, ones_rd;
    logic               busy, start, mult_en, fin, last_step, hi_zero;
    logic               unused_sdata;

    assign wr_ev        = swr && !swr_q;
    assign rd_ev        = srd && !srd_q;
    assign latch_ev     = gpio_latch && !latch_q;
    assign last_step    = step == SW'(DATA_W - 1);
    assign hi_zero      = (acc >> RES_W) == '0;
    assign unused_sdata = ^sdata_in;

`ifdef GPIO_MULCNT_POPCNT_EN
    localparam mulcnt_state_t MULT_NEXT = S_COUNT;
`else
    localparam mulcnt_state_t MULT_NEXT = S_DONE;
`endif

    always_ff @(posedge clk or negedge n_reset)
        if (!n_reset) state <= S_IDLE;
        else          state <= state_nxt;

    always_comb
        state_nxt = (state == S_IDLE)  ? (start ? S_MULT : S_IDLE) :
                    (state == S_MULT)  ? (last_step ? MULT_NEXT : S_MULT) :
                    (state == S_COUNT) ? S_DONE : S_IDLE;

    always_comb begin
        busy    = state != S_IDLE;
        start   = wr_ev && saddress == ADDR_CTRL && !busy;
        mult_en = state == S_MULT;
        fin     = state == S_DONE;
    end

`ifdef GPIO_MULCNT_POPCNT_EN
    localparam int PW = $clog2(RES_W + 1);
    logic          count_en;
    logic [PW-1:0] pop_cnt, pop_q, ones_q;

    popcount #(.W(RES_W)) u_popcount (
        .vec (acc[RES_W-1:0]),
        .cnt (pop_cnt)
    );

    assign count_en = state == S_COUNT;
    assign ones_rd  = 32'(ones_q);

    // Count is snapshotted in COUNT so ones only changes together with W in DONE
    always_ff @(posedge clk or negedge n_reset)
        if (!n_reset) begin
            pop_q  <= '0;
            ones_q <= '0;
        end else begin
            if (count_en) pop_q <= pop_cnt;
            if (fin) ones_q <= pop_q;
        end
`else
    assign ones_rd = '0;
`endif

    always_ff @(posedge clk or negedge n_reset)
        if (!n_reset) begin
            swr_q     <= 1'b0;
            srd_q     <= 1'b0;
            latch_q   <= 1'b0;
            gpio_in_s <= '0;
            a1_q      <= '0;
            a2_q      <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            step      <= '0;
            w_q       <= '0;
            valid_q   <= 1'b1;
            done_q    <= 1'b0;
            op_cnt    <= '0;
            sdata_out <= '0;
        end else begin
            swr_q   <= swr;
            srd_q   <= srd;
            latch_q <= gpio_latch;
            if (latch_ev) gpio_in_s <= gpio_in;
            if (wr_ev && !busy && saddress == ADDR_A1) a1_q <= DATA_W'(sdata_in);
            if (wr_ev && !busy && saddress == ADDR_A2) a2_q <= DATA_W'(sdata_in);
            if (start) begin
                mcand  <= AW'(a1_q);
                mplier <= a2_q;
                acc    <= '0;
                step   <= '0;
                done_q <= 1'b0;
            end
            if (mult_en) begin
                if (mplier[0]) acc <= acc + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                step   <= step + 1'b1;
            end
            if (fin) begin
                w_q     <= acc[RES_W-1:0];
                valid_q <= hi_zero;
                done_q  <= 1'b1;
                op_cnt  <= op_cnt + 1'b1;
            end
            if (rd_ev) sdata_out <= rd_data;
        end

    always_comb begin
        status             = '0;
        status[STAT_DONE]  = done_q;
        status[STAT_VALID] = valid_q;
        status[STAT_BUSY]  = busy;
        rd_data = (saddress == ADDR_W)    ? 32'(w_q) :
                  (saddress == ADDR_ONES) ? ones_rd :
                  (saddress == ADDR_CTRL) ? status : '0;
    end

    assign gpio_out       = 32'(op_cnt);
    assign gpio_in_s_insp = gpio_in_s;

endmodule

// File: tb/tb_gpio_mulcnt.sv
// tb_gpio_mulcnt: scoreboard bench for gpio_mulcnt; a CNT_W=4 twin shares the bus to exercise counter wrap.
module tb_gpio_mulcnt;

    import gpio_mulcnt_pkg::*;

    localparam int DATA_W = 24;
`ifdef GPIO_MULCNT_POPCNT_EN
    localparam bit POP = 1'b1;
`else
    localparam bit POP = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [31:0] exp;
    } rd_exp_t;

    logic        clk = 1'b0, n_reset = 1'b0, swr = 1'b0, srd = 1'b0, gpio_latch = 1'b0;
    logic [15:0] saddress = '0;
    logic [31:0] sdata_in = '0, gpio_in = '0;
    logic [31:0] sdata_out, gpio_out, gpio_in_s_insp;
    logic [31:0] sdata_out4, gpio_out4, gpio_in_s_insp4;
    rd_exp_t     sb[$];
    int          checks = 0, errors = 0, exp_cnt = 0;

    always #5 clk = ~clk;

    gpio_mulcnt dut (
        .clk(clk), .n_reset(n_reset), .saddress(saddress), .swr(swr), .srd(srd),
        .sdata_in(sdata_in), .sdata_out(sdata_out), .gpio_in(gpio_in),
        .gpio_latch(gpio_latch), .gpio_out(gpio_out), .gpio_in_s_insp(gpio_in_s_insp)
    );

    gpio_mulcnt #(.CNT_W(4)) dut4 (
        .clk(clk), .n_reset(n_reset), .saddress(saddress), .swr(swr), .srd(srd),
        .sdata_in(sdata_in), .sdata_out(sdata_out4), .gpio_in(gpio_in),
        .gpio_latch(gpio_latch), .gpio_out(gpio_out4), .gpio_in_s_insp(gpio_in_s_insp4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Each bus task starts and ends on a falling edge; the event is sampled at the rising edge in between
    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        saddress = a;
        sdata_in = d;
        swr = 1'b1;
        @(negedge clk);
        swr = 1'b0;
        @(negedge clk);
    endtask

    task automatic rd(input string name, input logic [15:0] a, input logic [31:0] exp);
        sb.push_back('{name, exp});
        saddress = a;
        srd = 1'b1;
        @(negedge clk);
        srd = 1'b0;
        @(negedge clk);
    endtask

    task automatic op(input logic [31:0] a, input logic [31:0] b);
        wr(ADDR_A1, a);
        wr(ADDR_A2, b);
        wr(ADDR_CTRL, 32'h0);
        repeat (DATA_W + 2) @(negedge clk);
        exp_cnt++;
    endtask

    // Monitor: every sampled srd rising edge yields one sdata_out value to score
    initial begin
        bit ev;
        bit prev;
        prev = 1'b0;
        forever begin
            @(posedge clk);
            ev   = srd && !prev;
            prev = srd;
            if (ev) begin
                @(negedge clk);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_read: got 0x%08h expected no read", sdata_out);
                end else begin
                    rd_exp_t e;
                    e = sb.pop_front();
                    check(e.name, sdata_out, e.exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
        check("reset_sdata_out", sdata_out, 32'h0);
        check("reset_gpio_out", gpio_out, 32'h0);
        check("reset_insp", gpio_in_s_insp, 32'h0);
        rd("reset_status", ADDR_CTRL, 32'h2);
        rd("reset_w", ADDR_W, 32'h0);
        rd("reset_ones", ADDR_ONES, 32'h0);
        rd("unmapped", 16'h0000, 32'h0);
        rd("a1_writeonly", ADDR_A1, 32'h0);

        gpio_in = 32'hDEADBEEF;
        gpio_latch = 1'b1;
        @(negedge clk);
        check("gpio_capture", gpio_in_s_insp, 32'hDEADBEEF);
        gpio_in = 32'h12345678;
        @(negedge clk);
        check("gpio_hold", gpio_in_s_insp, 32'hDEADBEEF);
        gpio_latch = 1'b0;
        @(negedge clk);
        gpio_latch = 1'b1;
        @(negedge clk);
        check("gpio_recapture", gpio_in_s_insp, 32'h12345678);
        gpio_latch = 1'b0;

        // 3*5: start sampled at edge 0, status read at edge 25 (still busy) and edge 27 (done)
        wr(ADDR_A1, 32'd3);
        wr(ADDR_A2, 32'd5);
        wr(ADDR_CTRL, 32'h0);
        repeat (23) @(negedge clk);
        rd("busy_status", ADDR_CTRL, 32'h6);
        rd("done_status", ADDR_CTRL, 32'h3);
        rd("w_3x5", ADDR_W, 32'd15);
        rd("ones_3x5", ADDR_ONES, POP ? 32'd4 : 32'd0);
        exp_cnt++;
        check("cnt_after_first", gpio_out, 32'd1);

        op(32'hFFFFFF, 32'hFFFFFF);
        rd("w_overflow", ADDR_W, 32'hFE000001);
        rd("status_overflow", ADDR_CTRL, 32'h1);
        rd("ones_overflow", ADDR_ONES, POP ? 32'd8 : 32'd0);
        check("cnt_after_overflow", gpio_out, 32'd2);

        // Writes and a second start during the operation must be ignored
        wr(ADDR_A1, 32'd3);
        wr(ADDR_A2, 32'd5);
        wr(ADDR_CTRL, 32'h0);
        repeat (3) @(negedge clk);
        wr(ADDR_A1, 32'd7);
        wr(ADDR_CTRL, 32'h0);
        repeat (DATA_W) @(negedge clk);
        exp_cnt++;
        rd("w_busy_write", ADDR_W, 32'd15);
        rd("status_busy_write", ADDR_CTRL, 32'h3);
        check("cnt_busy_write", gpio_out, 32'd3);
        wr(ADDR_CTRL, 32'h0);
        repeat (DATA_W + 2) @(negedge clk);
        exp_cnt++;
        rd("w_a1_kept", ADDR_W, 32'd15);
        check("cnt_a1_kept", gpio_out, 32'd4);

        // Reset around cycle 10 of an operation
        wr(ADDR_A1, 32'd2);
        wr(ADDR_A2, 32'd9);
        wr(ADDR_CTRL, 32'h0);
        repeat (8) @(negedge clk);
        n_reset = 1'b0;
        @(negedge clk);
        n_reset = 1'b1;
        exp_cnt = 0;
        check("midreset_gpio_out", gpio_out, 32'h0);
        check("midreset_insp", gpio_in_s_insp, 32'h0);
        repeat (DATA_W + 4) @(negedge clk);
        check("midreset_no_incr", gpio_out, 32'h0);
        rd("midreset_status", ADDR_CTRL, 32'h2);
        rd("midreset_w", ADDR_W, 32'h0);
        rd("midreset_ones", ADDR_ONES, 32'h0);
        op(32'd2, 32'd9);
        rd("w_after_reset", ADDR_W, 32'd18);
        rd("ones_after_reset", ADDR_ONES, POP ? 32'd2 : 32'd0);
        check("cnt_after_reset", gpio_out, 32'd1);

        // Held write strobe on the start address gives exactly one operation
        saddress = ADDR_CTRL;
        swr = 1'b1;
        repeat (5) @(negedge clk);
        swr = 1'b0;
        repeat (DATA_W + 4) @(negedge clk);
        exp_cnt++;
        check("held_strobe_cnt", gpio_out, 32'd2);
        rd("held_strobe_status", ADDR_CTRL, 32'h3);
        check("cnt4_before_wrap", gpio_out4, 32'd2);

        for (int i = 0; i < 14; i++) begin
            op(32'(i + 3), 32'(i + 7));
            rd($sformatf("w_loop%0d", i), ADDR_W, 32'((i + 3) * (i + 7)));
        end
        check("cnt_16", gpio_out, 32'(exp_cnt));
        check("cnt4_wrap", gpio_out4, 32'(exp_cnt % 16));

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
